// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with tagged direct-mapped BTB,
// speculative global history with repair, and resolution statistics.
module gshare_branch_predictor #(
   parameter int XLEN      = 32,
   parameter int IDX_W     = 10,
   parameter int GHR_W     = 10,
   parameter int CTR_W     = 2,
   parameter int BTB_IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lkp_valid,
   input  logic [XLEN-1:0]  lkp_pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_valid,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic             upd_is_jump,
   input  logic             upd_taken,
   input  logic [XLEN-1:0]  upd_target,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_mispredict,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_correct
);

   localparam int PHT_N = 1 << IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = XLEN - BTB_IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT =
      CTR_W'((1 << (CTR_W - 1)) - 1);

   logic [CTR_W-1:0] pht [PHT_N];
   logic             btb_vld [BTB_N];
   logic [TAG_W-1:0] btb_tag [BTB_N];
   logic [XLEN-1:0]  btb_tgt [BTB_N];
   logic             btb_jmp [BTB_N];

   logic [GHR_W-1:0]     ghr;
   logic [GHR_W-1:0]     rep_ghr;
   logic [GHR_W-1:0]     spc_ghr;
   logic [IDX_W-1:0]     lkp_idx;
   logic [IDX_W-1:0]     upd_idx;
   logic [BTB_IDX_W-1:0] lkp_bidx;
   logic [BTB_IDX_W-1:0] upd_bidx;
   logic [TAG_W-1:0]     lkp_tag;
   logic [TAG_W-1:0]     upd_tag;
   logic                 hit;
   logic                 upd_tk;
   logic [CTR_W-1:0]     ctr_cur;
   logic [CTR_W-1:0]     ctr_nxt;
   logic                 unused_ok;

   assign upd_tk   = upd_taken | upd_is_jump;
   assign lkp_idx  = lkp_pc[IDX_W+1:2] ^ IDX_W'(ghr);
   assign upd_idx  = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
   assign lkp_bidx = lkp_pc[BTB_IDX_W+1:2];
   assign upd_bidx = upd_pc[BTB_IDX_W+1:2];
   assign lkp_tag  = lkp_pc[XLEN-1:BTB_IDX_W+2];
   assign upd_tag  = upd_pc[XLEN-1:BTB_IDX_W+2];
   assign unused_ok = ^{lkp_pc[1:0], upd_pc[1:0]};

   assign hit = btb_vld[lkp_bidx] &&
                (btb_tag[lkp_bidx] == lkp_tag);
   assign pred_taken = hit &
      (pht[lkp_idx][CTR_W-1] | btb_jmp[lkp_bidx]);
   assign pred_target = hit ? btb_tgt[lkp_bidx] : '0;
   assign pred_ghr    = ghr;

   generate
      if (GHR_W == 1) begin : g_h1
         assign rep_ghr = upd_tk;
         assign spc_ghr = pred_taken;
      end else begin : g_hn
         assign rep_ghr = {upd_ghr[GHR_W-2:0], upd_tk};
         assign spc_ghr = {ghr[GHR_W-2:0], pred_taken};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ghr <= '0;
      else if (upd_valid && upd_mispredict)
         ghr <= rep_ghr;
      else if (lkp_valid && hit)
         ghr <= spc_ghr;
   end

   always_comb begin
      ctr_cur = pht[upd_idx];
      ctr_nxt = ctr_cur;
      if (upd_is_jump)
         ctr_nxt = CTR_MAX;
      else if (upd_taken) begin
         if (ctr_cur != CTR_MAX)
            ctr_nxt = ctr_cur + CTR_W'(1);
      end else if (ctr_cur != '0)
         ctr_nxt = ctr_cur - CTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHT_N; i++)
            pht[i] <= CTR_INIT;
      end else if (upd_valid)
         pht[upd_idx] <= ctr_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_N; i++)
            btb_vld[i] <= 1'b0;
      end else if (upd_valid && upd_tk)
         btb_vld[upd_bidx] <= 1'b1;
   end

   // payload is qualified by btb_vld, so it needs no reset
   always_ff @(posedge clk) begin
      if (upd_valid && upd_tk) begin
         btb_tag[upd_bidx] <= upd_tag;
         btb_tgt[upd_bidx] <= upd_target;
         btb_jmp[upd_bidx] <= upd_is_jump;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches <= '0;
         stat_correct  <= '0;
      end else if (upd_valid) begin
         if (stat_branches != '1)
            stat_branches <= stat_branches + 32'd1;
         if (!upd_mispredict && stat_correct != '1)
            stat_correct <= stat_correct + 32'd1;
      end
   end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed self-checking bench for gshare_branch_predictor
// with default parameters.
module tb_gshare_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lkp_valid;
   logic [31:0] lkp_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [9:0]  pred_ghr;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_jump;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [9:0]  upd_ghr;
   logic        upd_mispredict;
   logic [31:0] stat_branches;
   logic [31:0] stat_correct;

   int checks = 0;
   int failures = 0;

   gshare_branch_predictor dut (
      .clk(clk), .rst_n(rst_n),
      .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
      .pred_taken(pred_taken),
      .pred_target(pred_target),
      .pred_ghr(pred_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken),
      .upd_target(upd_target),
      .upd_ghr(upd_ghr),
      .upd_mispredict(upd_mispredict),
      .stat_branches(stat_branches),
      .stat_correct(stat_correct)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc,
                      input logic jmp, input logic tk,
                      input logic [31:0] tgt,
                      input logic [9:0] gh,
                      input logic mis);
      upd_valid = 1'b1; upd_pc = pc;
      upd_is_jump = jmp; upd_taken = tk;
      upd_target = tgt; upd_ghr = gh;
      upd_mispredict = mis;
      tick();
      upd_valid = 1'b0;
      lkp_valid = 1'b0;
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      lkp_pc = pc;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      lkp_valid = 1'b1; lkp_pc = 32'h100;
      upd_valid = 1'b0; upd_pc = '0;
      upd_is_jump = 1'b0; upd_taken = 1'b0;
      upd_target = '0; upd_ghr = '0;
      upd_mispredict = 1'b0;
      #2;
      chk("rst_taken", {31'd0, pred_taken}, 0);
      chk("rst_target", pred_target, 0);
      chk("rst_ghr", {22'd0, pred_ghr}, 0);
      chk("rst_br", stat_branches, 0);
      chk("rst_ok", stat_correct, 0);
      #10 rst_n = 1'b1;
      tick();
      chk("miss_ghr", {22'd0, pred_ghr}, 0);
      chk("miss_taken", {31'd0, pred_taken}, 0);
      lkp_valid = 1'b0;

      upd(32'h100, 0, 1, 32'h80, 10'h0, 1);
      look(32'h100);
      chk("t1_ghr", {22'd0, pred_ghr}, 32'h1);
      chk("t1_taken", {31'd0, pred_taken}, 0);
      chk("t1_target", pred_target, 32'h80);
      chk("t1_br", stat_branches, 1);
      chk("t1_ok", stat_correct, 0);

      upd(32'h800, 0, 0, 32'h0, 10'h0, 1);
      look(32'h100);
      chk("g0_ghr", {22'd0, pred_ghr}, 0);
      chk("ctr2_taken", {31'd0, pred_taken}, 1);

      for (int i = 0; i < 4; i++)
         upd(32'h100, 0, 1, 32'h80, 10'h0, 0);
      look(32'h100);
      chk("sat3_taken", {31'd0, pred_taken}, 1);
      upd(32'h100, 0, 0, 32'h0, 10'h0, 0);
      chk("nt1_taken", {31'd0, pred_taken}, 1);
      upd(32'h100, 0, 0, 32'h0, 10'h0, 0);
      chk("nt2_taken", {31'd0, pred_taken}, 0);
      upd(32'h100, 0, 0, 32'h0, 10'h0, 0);
      upd(32'h100, 0, 0, 32'h0, 10'h0, 0);
      chk("nt4_taken", {31'd0, pred_taken}, 0);
      upd(32'h100, 0, 0, 32'h0, 10'h0, 0);
      chk("nt5_taken", {31'd0, pred_taken}, 0);
      chk("nt_target", pred_target, 32'h80);
      chk("loop_br", stat_branches, 11);
      chk("loop_ok", stat_correct, 9);

      upd(32'h200, 1, 0, 32'h400, 10'h155, 1);
      look(32'h100);
      chk("alias_taken", {31'd0, pred_taken}, 0);
      chk("alias_target", pred_target, 0);
      look(32'h200);
      chk("jal_ghr", {22'd0, pred_ghr}, 32'h2AB);
      chk("jal_taken", {31'd0, pred_taken}, 1);
      chk("jal_target", pred_target, 32'h400);
      lkp_valid = 1'b1;
      tick();
      lkp_valid = 1'b0;
      #1;
      chk("shift_ghr", {22'd0, pred_ghr}, 32'h157);
      chk("jal2_taken", {31'd0, pred_taken}, 1);
      chk("jal2_target", pred_target, 32'h400);

      upd(32'h800, 0, 0, 32'h0, 10'h155, 1);
      chk("set_ghr", {22'd0, pred_ghr}, 32'h2AA);
      chk("set_taken", {31'd0, pred_taken}, 1);
      lkp_valid = 1'b1;
      upd(32'h800, 0, 0, 32'h0, 10'h0F0, 1);
      chk("repair_ghr", {22'd0, pred_ghr}, 32'h1E0);
      chk("repair_br", stat_branches, 14);
      chk("repair_ok", stat_correct, 9);

      upd_valid = 1'b1; upd_pc = 32'h300;
      upd_is_jump = 1'b0; upd_taken = 1'b1;
      upd_target = 32'h500; upd_mispredict = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_taken", {31'd0, pred_taken}, 0);
      chk("mrst_ghr", {22'd0, pred_ghr}, 0);
      chk("mrst_br", stat_branches, 0);
      chk("mrst_ok", stat_correct, 0);
      rst_n = 1'b1;
      upd_valid = 1'b0;
      tick();
      look(32'h200);
      chk("post_taken", {31'd0, pred_taken}, 0);
      chk("post_target", pred_target, 0);
      look(32'h300);
      chk("post_abort", pred_target, 0);
      chk("post_br", stat_branches, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
